// File: rtl/dmem_latency_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Brief    : Shared FSM state codes, access-size codes and alignment check.
// Revision : 1.0
// ============================================================================
package dmem_pkg;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  typedef logic [1:0] size_t;
  localparam size_t SZ_BYTE = 2'd0;
  localparam size_t SZ_HALF = 2'd1;
  localparam size_t SZ_WORD = 2'd2;

  function automatic logic is_misaligned(input logic [1:0] addr_lo, input size_t size);
    case (size)
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return (addr_lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_latency_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_latency_ctrl_if
// Brief    : Request/response channel bundle between a master and the DMEM.
// Revision : 1.0
// ============================================================================
interface dmem_latency_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_write;
  logic                  req_byte;
  logic                  req_half_word;
  logic                  req_sign_extend;
  logic [31:0]           req_data;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_data;
  logic                  resp_error;

  modport master (
    output req_valid, req_addr, req_write, req_byte, req_half_word,
           req_sign_extend, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_error
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_byte, req_half_word,
           req_sign_extend, req_data, resp_ready,
    output req_ready, resp_valid, resp_data, resp_error
  );
endinterface
`default_nettype wire

// File: rtl/dmem_lane_format.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lane_format
// Brief    : Big-endian lane steering: load extract/extend, store byte enables.
// Revision : 1.0
// ============================================================================
module dmem_lane_format
  import dmem_pkg::*;
(
  input  size_t       size_i,
  input  logic [1:0]  offset_i,
  input  logic        sign_ext_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rd_word_i,
  output logic [31:0] load_data_o,
  output logic [31:0] wr_word_o,
  output logic [3:0]  wr_en_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane k is the byte at aligned base + k; lane 0 sits in the MSBs.
  always_comb begin
    case (offset_i)
      2'd0:    w_byte = rd_word_i[31:24];
      2'd1:    w_byte = rd_word_i[23:16];
      2'd2:    w_byte = rd_word_i[15:8];
      default: w_byte = rd_word_i[7:0];
    endcase
    w_half = offset_i[1] ? rd_word_i[15:0] : rd_word_i[31:16];

    load_data_o = rd_word_i;
    wr_word_o   = store_data_i;
    wr_en_o     = 4'b1111;
    case (size_i)
      SZ_BYTE: begin
        load_data_o = {{24{sign_ext_i & w_byte[7]}}, w_byte};
        wr_word_o   = {4{store_data_i[7:0]}};
        wr_en_o     = 4'b0001 << offset_i;
      end
      SZ_HALF: begin
        load_data_o = {{16{sign_ext_i & w_half[15]}}, w_half};
        wr_word_o   = {2{store_data_i[15:0]}};
        wr_en_o     = offset_i[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_latency_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_latency_ctrl
// Brief    : Byte-addressed big-endian data memory with configurable latency.
//            Define DMEM_MISALIGN_TRAP_EN to fault misaligned accesses.
// Revision : 1.0
// ============================================================================
module dmem_latency_ctrl
  import dmem_pkg::*;
#(
  parameter int SIZE       = 16384,
  parameter int ADDR_WIDTH = 32,
  parameter int LATENCY    = 1
)(
  input  logic                 clock,
  input  logic                 reset,
  dmem_latency_ctrl_if.slave   bus
);

  localparam int         MEM_AW   = $clog2(SIZE);
  localparam logic [2:0] CNT_LOAD = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

  logic [7:0] mem [SIZE];

  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [MEM_AW-1:0]  addr_q;
  size_t              size_q;
  logic               write_q;
  logic               sext_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic               err_q;

  logic               w_in_idle;
  logic               w_accept;
  logic               w_access;
  size_t              w_req_size;
  logic [MEM_AW-1:0]  w_acc_addr;
  size_t              w_acc_size;
  logic               w_acc_write;
  logic               w_acc_sext;
  logic [31:0]        w_acc_wdata;
  logic [MEM_AW-3:0]  w_base_hi;
  logic [31:0]        w_rd_word;
  logic [31:0]        w_load_data;
  logic [31:0]        w_wr_word;
  logic [3:0]         w_wr_en;
  logic               w_fault;

  generate
    if (ADDR_WIDTH > MEM_AW) begin : g_addr_hi
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^bus.req_addr[ADDR_WIDTH-1:MEM_AW];
    end
  endgenerate

  assign w_in_idle     = (state_q == ST_IDLE);
  assign bus.req_ready = w_in_idle && !reset;
  assign w_accept      = bus.req_valid && bus.req_ready;
  assign w_req_size    = bus.req_byte ? SZ_BYTE : (bus.req_half_word ? SZ_HALF : SZ_WORD);

  // With LATENCY 1 the access happens on the accept edge, straight from the request.
  assign w_acc_addr  = w_in_idle ? bus.req_addr[MEM_AW-1:0] : addr_q;
  assign w_acc_size  = w_in_idle ? w_req_size               : size_q;
  assign w_acc_write = w_in_idle ? bus.req_write            : write_q;
  assign w_acc_sext  = w_in_idle ? bus.req_sign_extend      : sext_q;
  assign w_acc_wdata = w_in_idle ? bus.req_data             : wdata_q;

  assign w_access = (w_accept && (LATENCY == 1)) ||
                    ((state_q == ST_WAIT) && (cnt_q == 3'd0));

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_fault = is_misaligned(w_acc_addr[1:0], w_acc_size);
`else
  assign w_fault = 1'b0;
`endif

  assign w_base_hi = w_acc_addr[MEM_AW-1:2];
  assign w_rd_word = {mem[{w_base_hi, 2'd0}], mem[{w_base_hi, 2'd1}],
                      mem[{w_base_hi, 2'd2}], mem[{w_base_hi, 2'd3}]};

  dmem_lane_format u_lane_format (
    .size_i       (w_acc_size),
    .offset_i     (w_acc_addr[1:0]),
    .sign_ext_i   (w_acc_sext),
    .store_data_i (w_acc_wdata),
    .rd_word_i    (w_rd_word),
    .load_data_o  (w_load_data),
    .wr_word_o    (w_wr_word),
    .wr_en_o      (w_wr_en)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 3'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 3'd1;
      end
      ST_RESP: begin
        if (bus.resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (w_access) begin
        rdata_q <= (w_acc_write || w_fault) ? 32'd0 : w_load_data;
        err_q   <= w_fault;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_accept) begin
      addr_q  <= bus.req_addr[MEM_AW-1:0];
      size_q  <= w_req_size;
      write_q <= bus.req_write;
      sext_q  <= bus.req_sign_extend;
      wdata_q <= bus.req_data;
    end
  end

  // Storage is deliberately outside reset so preloaded contents survive it.
  always_ff @(posedge clock) begin
    if (!reset && w_access && w_acc_write && !w_fault) begin
      for (int k = 0; k < 4; k++) begin
        if (w_wr_en[k]) mem[{w_base_hi, 2'(k)}] <= w_wr_word[8*(3-k) +: 8];
      end
    end
  end

  assign bus.resp_valid = (state_q == ST_RESP) && !reset;
  assign bus.resp_data  = reset ? 32'd0 : rdata_q;
  assign bus.resp_error = reset ? 1'b0  : err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_latency_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_latency_ctrl
// Brief    : Directed vector bench for dmem_latency_ctrl at LATENCY 3.
// Revision : 1.0
// ============================================================================
module tb_dmem_latency_ctrl;

  localparam int LAT  = 3;
  localparam int SIZE = 16384;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic        by;
    logic        hw;
    logic        sx;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  dmem_latency_ctrl_if #(.ADDR_WIDTH(32)) bus ();

  dmem_latency_ctrl #(
    .SIZE       (SIZE),
    .ADDR_WIDTH (32),
    .LATENCY    (LAT)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v);
    bus.req_valid       = 1'b1;
    bus.req_addr        = v.addr;
    bus.req_write       = v.wr;
    bus.req_byte        = v.by;
    bus.req_half_word   = v.hw;
    bus.req_sign_extend = v.sx;
    bus.req_data        = v.wdata;
  endtask

  task automatic access(input vec_t v, output logic [31:0] data, output logic err, output int lat);
    int guard;
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    drive_req(v);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("ready_low_after_accept", {31'd0, bus.req_ready}, 32'd0);
    lat = 1;
    while (!bus.resp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    data = bus.resp_data;
    err  = bus.resp_error;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  function automatic logic [31:0] mem_word(input int a);
    return {dut.mem[a], dut.mem[a+1], dut.mem[a+2], dut.mem[a+3]};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[$];
    vec_t        sv;
    logic [31:0] d;
    logic        e;
    int          lat;
    logic        seen_valid;
    int          guard;

    bus.req_valid       = 1'b0;
    bus.req_addr        = 32'd0;
    bus.req_write       = 1'b0;
    bus.req_byte        = 1'b0;
    bus.req_half_word   = 1'b0;
    bus.req_sign_extend = 1'b0;
    bus.req_data        = 32'd0;
    bus.resp_ready      = 1'b0;

    //            addr         wr by hw sx wdata          exp_data      err
    vecs.push_back('{32'h10,   1, 0, 0, 0, 32'hDEADBEEF, 32'h00000000, 0});
    vecs.push_back('{32'h11,   0, 1, 0, 1, 32'h0,        32'hFFFFFFAD, 0});
    vecs.push_back('{32'h11,   0, 1, 0, 0, 32'h0,        32'h000000AD, 0});
    vecs.push_back('{32'h12,   0, 0, 1, 1, 32'h0,        32'hFFFFBEEF, 0});
    vecs.push_back('{32'h12,   0, 0, 1, 0, 32'h0,        32'h0000BEEF, 0});
`ifdef DMEM_MISALIGN_TRAP_EN
    vecs.push_back('{32'h13,   0, 0, 0, 0, 32'h0,        32'h00000000, 1});
`else
    vecs.push_back('{32'h13,   0, 0, 0, 0, 32'h0,        32'hDEADBEEF, 0});
`endif
    vecs.push_back('{32'h4010, 0, 0, 0, 0, 32'h0,        32'hDEADBEEF, 0});
    vecs.push_back('{32'h14,   1, 0, 0, 0, 32'h11223344, 32'h00000000, 0});
    vecs.push_back('{32'h14,   1, 1, 0, 0, 32'h12345680, 32'h00000000, 0});
    vecs.push_back('{32'h16,   1, 0, 1, 0, 32'hAAAA7F01, 32'h00000000, 0});
    vecs.push_back('{32'h14,   0, 0, 0, 0, 32'h0,        32'h80227F01, 0});
    vecs.push_back('{32'h14,   0, 1, 0, 1, 32'h0,        32'hFFFFFF80, 0});
    vecs.push_back('{32'h17,   0, 1, 0, 1, 32'h0,        32'h00000001, 0});
`ifdef DMEM_MISALIGN_TRAP_EN
    vecs.push_back('{32'h15,   1, 0, 1, 0, 32'h00005555, 32'h00000000, 1});
    vecs.push_back('{32'h14,   0, 0, 0, 0, 32'h0,        32'h80227F01, 0});
    vecs.push_back('{32'h13,   0, 0, 1, 0, 32'h0,        32'h00000000, 1});
`else
    vecs.push_back('{32'h15,   1, 0, 1, 0, 32'h00005555, 32'h00000000, 0});
    vecs.push_back('{32'h14,   0, 0, 0, 0, 32'h0,        32'h55557F01, 0});
    vecs.push_back('{32'h13,   0, 0, 1, 0, 32'h0,        32'h0000BEEF, 0});
`endif
    vecs.push_back('{32'h30,   1, 0, 0, 0, 32'h11111111, 32'h00000000, 0});
    vecs.push_back('{32'h4012, 0, 0, 1, 0, 32'h0,        32'h0000BEEF, 0});
    vecs.push_back('{32'h10,   0, 1, 1, 0, 32'h0,        32'h000000DE, 0});
    vecs.push_back('{32'h20,   1, 0, 0, 0, 32'hCAFEF00D, 32'h00000000, 0});

    // Reset values, then release.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready",  {31'd0, bus.req_ready},  32'd0);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_data",  bus.resp_data,           32'd0);
    chk("rst_resp_error", {31'd0, bus.resp_error}, 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset", {31'd0, bus.req_ready}, 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      access(vecs[i], d, e, lat);
      chk($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
      chk($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
    end

    chk("mem_10_13", mem_word(32'h10), 32'hDEADBEEF);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("mem_14_17", mem_word(32'h14), 32'h80227F01);
`else
    chk("mem_14_17", mem_word(32'h14), 32'h55557F01);
`endif

    // Held response under back-pressure with a competing request.
    sv = '{32'h10, 0, 0, 0, 0, 32'h0, 32'h0, 0};
    drive_req(sv);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    guard = 0;
    while (!bus.resp_valid && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("stall_resp_arrives", {31'd0, bus.resp_valid}, 32'd1);
    sv = '{32'h30, 1, 0, 0, 0, 32'h01020304, 32'h0, 0};
    drive_req(sv);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d_valid", c), {31'd0, bus.resp_valid}, 32'd1);
      chk($sformatf("stall%0d_data", c),  bus.resp_data,           32'hDEADBEEF);
      chk($sformatf("stall%0d_ready", c), {31'd0, bus.req_ready},  32'd0);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk("stall_release_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("stall_release_ready", {31'd0, bus.req_ready},  32'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("stall_no_queue_mem", mem_word(32'h30), 32'h11111111);
    chk("stall_no_queue_valid", {31'd0, bus.resp_valid}, 32'd0);

    // Reset while the store sits in WAIT.
    sv = '{32'h20, 1, 0, 0, 0, 32'h0BADBEEF, 32'h0, 0};
    drive_req(sv);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("wait_accepted", {31'd0, bus.req_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("wait_rst_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("wait_rst_ready", {31'd0, bus.req_ready},  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("wait_rst_ready_after", {31'd0, bus.req_ready}, 32'd1);
    seen_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      seen_valid = seen_valid | bus.resp_valid;
    end
    chk("wait_rst_no_resp", {31'd0, seen_valid}, 32'd0);
    chk("wait_rst_mem_20_23", mem_word(32'h20), 32'hCAFEF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_latency_ctrl.md
Name: dmem_latency_ctrl

Overview:
- Parametrised successor to the single-cycle data memory used by the processor benches.
- Byte-addressed, big-endian data memory with:
  - a valid/ready request channel;
  - a configurable access latency;
  - a held response channel;
  - byte, half-word and word accesses with sign/zero extension.
- Sits between the processor's DMEM port (or a stall-capable wrapper) and the bench, so multi-cycle memory and stall logic can be exercised.
- Storage is a byte array named `mem` of SIZE entries. Benches preload it hierarchically and dump it after the run.

Parameters:
- SIZE, 16384: bytes of storage. Must be a power of two. Address wraps modulo SIZE.
- ADDR_WIDTH, 32: request address width.
- LATENCY, 1: cycles from request accept edge to resp_valid high. Legal range 1..8.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset. Sampled on the rising edge of clock.
- req_valid  in  1  request present.
- req_ready  out  1  controller idle; request accepted when req_valid && req_ready.
- req_addr  in  ADDR_WIDTH  byte address.
- req_write  in  1  1 = store, 0 = load.
- req_byte  in  1  byte access. Has priority over req_half_word.
- req_half_word  in  1  half-word access.
- req_sign_extend  in  1  sign-extend a load; 0 = zero-extend.
- req_data  in  32  store data, right-justified for byte and half-word stores.
- resp_valid  out  1  response held until accepted.
- resp_ready  in  1  consumer accepts the response.
- resp_data  out  32  load result. 0 for stores.
- resp_error  out  1  access faulted. Only asserts with the optional feature.

Behaviour:
- States:
  - IDLE: req_ready = 1.
  - WAIT: down-counter running.
  - RESP: resp_valid = 1.
- While reset is high: state IDLE, counter 0, and req_ready = 0, resp_valid = 0, resp_data = 0, resp_error = 0. req_ready rises in the first cycle after reset falls. Reset never clears `mem`.
- IDLE:
  - On accept, latch addr, size, write, sign_extend and data.
  - LATENCY = 1: go directly to RESP, performing the access on the accept edge.
  - Otherwise: load counter with LATENCY-2 and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - On the edge where the counter is 0, perform the access and enter RESP.
- Access timing: a write commits to `mem` only on the edge that enters RESP. Load data is captured into resp_data on that same edge.
- RESP:
  - resp_valid, resp_data and resp_error are held stable until resp_ready = 1.
  - On that edge, return to IDLE and clear resp_valid.
  - req_valid is ignored outside IDLE; there is no queuing.
- Addressing: a = req_addr mod SIZE.
  - Word: bytes a..a+3, mem[a] is the MSB.
  - Half-word: {mem[a], mem[a+1]} in the low 16 bits.
  - Byte: mem[a] in the low 8 bits.
  - Upper bits are filled with the sign bit if req_sign_extend = 1, else with 0.
- Stores write only the addressed bytes, taking the low 8, low 16 or all 32 bits of req_data. Byte a+k wraps modulo SIZE.
- Misalignment: a half-word at an odd address, or a word at a%4 != 0.
  - Without the optional feature, the low address bits are forced to 0 (aligned down) and resp_error = 0.
- Reset mid-operation drops the pending request. No write commits and no response is issued.
- Throughput: one access per LATENCY+1 cycles, with resp_ready held at 1.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- When defined, a misaligned access performs no memory read or write. Its response is resp_error = 1 and resp_data = 0, with the same latency as a normal access.
- When undefined, misaligned accesses are aligned down as described in Behaviour and resp_error is tied to 0.

Decomposition:
- Package dmem_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - size encoding constants (SZ_BYTE, SZ_HALF, SZ_WORD);
  - an is_misaligned(addr, size) function.
- Sub-module dmem_lane_format: a combinational block that extracts and extends load data and generates per-byte store data and write enables from size, address low bits and sign_extend.

Test Plan:
- LATENCY=3, store word 0xDEADBEEF to 0x10 -> req_ready low after accept; resp_valid exactly 3 cycles after the accept edge; mem[0x10..0x13] = DE, AD, BE, EF.
- Byte load at 0x11:
  - sign_extend=1 -> 0xFFFFFFAD;
  - sign_extend=0 -> 0x000000AD;
  - half-word load at 0x12 signed -> 0xFFFFBEEF.
- Word load at 0x13:
  - without the macro -> 0xDEADBEEF, resp_error = 0;
  - with DMEM_MISALIGN_TRAP_EN -> resp_error = 1, resp_data = 0;
  - with the macro, a misaligned store leaves mem unchanged.
- Hold resp_ready=0 for 5 cycles -> resp_valid and resp_data stay stable, req_ready stays 0, and a concurrent req_valid is not accepted.
- Reset asserted in WAIT during a store to 0x20 -> mem[0x20..0x23] unchanged, no resp_valid, req_ready = 1 on the first cycle after reset falls.
- SIZE=16384, load word at 0x4010 -> returns the same data as 0x10 (wrap).
